// File: rtl/ifetch_prefetch.sv
// Instruction-fetch stage: fetch PC, byte-loadable instruction memory with a one-cycle
// synchronous read, and a prefetch FIFO of {pc, instr} pairs feeding the decode stage.
module ifetch_prefetch #(
    parameter int PC_SIZE      = 32,
    parameter int INST_SIZE    = 32,
    parameter int INSTMEM_ADDR = 8,
    parameter int DATA_SIZE    = 8,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_pc_en,
    input  logic                             i_stall,
    input  logic                             i_branch,
    input  logic                             i_jal,
    input  logic                             i_jalr,
    input  logic [PC_SIZE-1:0]               i_branch_addr,
    input  logic [PC_SIZE-1:0]               i_jump_addr,
    input  logic [PC_SIZE-1:0]               i_last_reg,
    input  logic                             i_load_mode,
    input  logic                             i_load_we,
    input  logic [INSTMEM_ADDR-1:0]          i_load_addr,
    input  logic [DATA_SIZE-1:0]             i_load_data,
    output logic [PC_SIZE-1:0]               o_pc,
    output logic [PC_SIZE-1:0]               o_next_pc,
    output logic [INST_SIZE-1:0]             o_instr,
    output logic                             o_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_count
);

    localparam int LANES = INST_SIZE / DATA_SIZE;
    localparam int LB    = $clog2(LANES);
    localparam int WA    = INSTMEM_ADDR - LB;
    localparam int WORDS = 1 << WA;
    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = $clog2(QUEUE_DEPTH + 1);

    logic [PC_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [PC_SIZE-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    logic [PC_SIZE-1:0]   q_pc_q    [QUEUE_DEPTH];
    logic [INST_SIZE-1:0] q_instr_q [QUEUE_DEPTH];

    logic [DATA_SIZE-1:0] rd_lane_q [LANES];
    logic [INST_SIZE-1:0] rd_data;
    logic [LANES-1:0]     lane_we;
    logic [WA-1:0]        rd_idx;
    logic [WA-1:0]        wr_idx;
    logic                 load_wr;

    logic                 redirect;
    logic                 flush;
    logic [PC_SIZE-1:0]   target;
    logic [CW:0]          occupancy;
    logic                 issue;
    logic                 push;
    logic                 pop;

    assign redirect  = i_jalr | i_jal | i_branch;
    assign flush     = redirect | i_load_mode;
    assign target    = i_jalr ? i_last_reg : (i_jal ? i_jump_addr : i_branch_addr);
    // Reads still in flight hold a reserved slot so a stalled queue can never overflow.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue     = i_pc_en & ~i_load_mode & ~redirect &
                       (occupancy < (CW + 1)'(QUEUE_DEPTH));
    assign push      = inflight_q;
    assign pop       = (count_q != '0) & ~i_stall;

    assign load_wr   = i_load_mode & i_load_we & ~i_reset;
    assign rd_idx    = fetch_pc_q[INSTMEM_ADDR-1:LB];
    assign wr_idx    = i_load_addr[INSTMEM_ADDR-1:LB];

    // One byte-wide RAM per lane so the loader can write single bytes (little-endian).
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_SIZE-1:0] lane_mem [WORDS];

            assign lane_we[gi] = load_wr && (i_load_addr[LB-1:0] == LB'(gi));
            assign rd_data[gi*DATA_SIZE +: DATA_SIZE] = rd_lane_q[gi];

            always_ff @(posedge i_clock) begin
                if (lane_we[gi]) begin
                    lane_mem[wr_idx] <= i_load_data;
                end
                if (issue) begin
                    rd_lane_q[gi] <= lane_mem[rd_idx];
                end
            end
        end
    endgenerate

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            if (redirect) begin
                fetch_pc_d = target & ~PC_SIZE'(3);
            end
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_SIZE'(4);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Slot contents need no reset: occupancy alone decides what is visible.
    always_ff @(posedge i_clock) begin
        if (!i_reset && !flush && push) begin
            q_pc_q[tail_q]    <= inflight_pc_q;
            q_instr_q[tail_q] <= rd_data;
        end
    end

    assign o_valid   = (count_q != '0);
    assign o_count   = count_q;
    assign o_pc      = o_valid ? q_pc_q[head_q] : '0;
    assign o_next_pc = o_pc + PC_SIZE'(4);
    assign o_instr   = o_valid ? q_instr_q[head_q] : '0;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the fetch stage.
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, stall, branch, jal, jalr;
    logic [31:0] branch_addr, jump_addr, last_reg;
    logic        load_mode, load_we;
    logic [7:0]  load_addr, load_data;
    logic [31:0] o_pc, o_next_pc, o_instr;
    logic        o_valid;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_prefetch dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_pc_en      (pc_en),
        .i_stall      (stall),
        .i_branch     (branch),
        .i_jal        (jal),
        .i_jalr       (jalr),
        .i_branch_addr(branch_addr),
        .i_jump_addr  (jump_addr),
        .i_last_reg   (last_reg),
        .i_load_mode  (load_mode),
        .i_load_we    (load_we),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .o_pc         (o_pc),
        .o_next_pc    (o_next_pc),
        .o_instr      (o_instr),
        .o_valid      (o_valid),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    // Reference model: byte memory, list of queued {pc,instr}, one pending read.
    logic [7:0]  mem_m [256];
    logic [63:0] mq [$];
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [63:0] m_infl_e;
    logic        m_popped;
    logic [63:0] m_pop_e;

    function automatic logic [31:0] mword(input logic [31:0] pc);
        int base;
        base = int'(pc[7:2]) * 4;
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    task automatic model_step();
        logic do_issue;
        m_popped = 1'b0;
        if (rst) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = 32'h0;
        end else begin
            if (load_mode && load_we) mem_m[load_addr] = load_data;
            if (jalr || jal || branch) begin
                mq.delete();
                m_infl = 1'b0;
                m_fpc  = (jalr ? last_reg : (jal ? jump_addr : branch_addr)) & 32'hFFFF_FFFC;
            end else if (load_mode) begin
                mq.delete();
                m_infl = 1'b0;
            end else begin
                do_issue = pc_en && ((mq.size() + int'(m_infl)) < 4);
                if (mq.size() > 0 && !stall) begin
                    m_pop_e  = mq.pop_front();
                    m_popped = 1'b1;
                end
                if (m_infl) mq.push_back(m_infl_e);
                m_infl = do_issue;
                if (do_issue) begin
                    m_infl_e = {m_fpc, mword(m_fpc)};
                    m_fpc    = m_fpc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", o_count); end
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0", o_pc); end
        n_checks++; if (o_next_pc !== 32'h4) begin n_fail++; $display("FAIL reset_next_pc got=%h want=4", o_next_pc); end
        n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h want=0", o_instr); end
        rst = 1'b0;
        $display("txn reset: valid=%0b count=%0d pc=%h", o_valid, o_count, o_pc);
    endtask

    task automatic load_image();
        logic [31:0] words [3];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        load_mode = 1'b1;
        load_we   = 1'b1;
        for (int a = 0; a < 256; a++) begin
            load_addr = 8'(a);
            if (a < 12) load_data = words[a/4][8*(a%4) +: 8];
            else        load_data = 8'($urandom);
            tick();
        end
        load_we   = 1'b0;
        load_mode = 1'b0;
        tick();
        $display("txn load_image: 256 bytes written");
    endtask

    task automatic test_basic();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h1111_1111;
        exp_i[1] = 32'h2222_2222;
        exp_i[2] = 32'h3333_3333;
        pc_en = 1'b1;
        stall = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got=%0b want=0", o_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4*i) || o_instr !== exp_i[i] || o_next_pc !== 32'(4*i+4)) begin
                n_fail++;
                $display("FAIL basic_seq%0d got v=%0b pc=%h npc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, o_valid, o_pc, o_next_pc, o_instr, 32'(4*i), exp_i[i]);
            end
            $display("txn fetch pc=%h instr=%h", o_pc, o_instr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL stall_count got=%0d want=4", o_count); end
        n_checks++; if (o_pc !== 32'h8) begin n_fail++; $display("FAIL stall_head got=%h want=8", o_pc); end
        stall  = 1'b0;
        exp_pc = 32'h8;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== exp_pc || o_instr !== mword(exp_pc)) begin
                n_fail++;
                $display("FAIL stall_drain%0d got v=%0b pc=%h ins=%h want pc=%h ins=%h",
                         i, o_valid, o_pc, o_instr, exp_pc, mword(exp_pc));
            end
            $display("txn drain pc=%h instr=%h", o_pc, o_instr);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        for (int i = 0; i < 20 && o_count !== 3'd4; i++) tick();
        stall = 1'b0;
        tick();
        n_checks++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL redir_setup got=%0d want=3", o_count); end
        stall       = 1'b1;
        branch      = 1'b1;
        branch_addr = 32'h40;
        jalr        = 1'b1;
        last_reg    = 32'h80;
        tick();
        branch = 1'b0;
        jalr   = 1'b0;
        n_checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got count=%0d v=%0b want 0", o_count, o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_early got=%0b want=0", o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h80) begin n_fail++; $display("FAIL redir_target got v=%0b pc=%h want v=1 pc=80", o_valid, o_pc); end
        $display("txn redirect pc=%h instr=%h", o_pc, o_instr);
    endtask

    task automatic test_jal_wrap();
        jal       = 1'b1;
        jump_addr = 32'h102;
        tick();
        jal = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL jal_wrap got v=%0b pc=%h ins=%h want pc=100 ins=11111111", o_valid, o_pc, o_instr);
        end
        $display("txn jal pc=%h instr=%h", o_pc, o_instr);
    endtask

    task automatic test_reset_midrun();
        stall = 1'b1;
        pc_en = 1'b1;
        for (int i = 0; i < 20 && o_count !== 3'd3; i++) tick();
        n_checks++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL midrst_setup got=%0d want=3", o_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_state got v=%0b cnt=%0d pc=%h want 0/0/0", o_valid, o_count, o_pc);
        end
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_first got v=%0b pc=%h want v=1 pc=0", o_valid, o_pc); end
        $display("txn reset_midrun first pc=%h", o_pc);
    endtask

    task automatic test_load_mode();
        logic [31:0] nw;
        nw = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && o_count !== 3'd2; i++) tick();
        n_checks++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL load_setup got=%0d want=2", o_count); end
        load_mode = 1'b1;
        load_we   = 1'b1;
        for (int b = 0; b < 4; b++) begin
            load_addr = 8'(8 + b);
            load_data = nw[8*b +: 8];
            tick();
            if (b == 0) begin
                n_checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL load_flush got cnt=%0d v=%0b want 0", o_count, o_valid); end
            end
        end
        load_mode = 1'b0;
        load_we   = 1'b0;
        stall     = 1'b0;
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'hC) begin n_fail++; $display("FAIL load_resume got v=%0b pc=%h want v=1 pc=c", o_valid, o_pc); end
        branch      = 1'b1;
        branch_addr = 32'h8;
        tick();
        branch = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_refetch got v=%0b pc=%h ins=%h want pc=8 ins=deadbeef", o_valid, o_pc, o_instr);
        end
        $display("txn load refetch pc=%h instr=%h", o_pc, o_instr);
    endtask

    task automatic test_random();
        int lm_left = 0;
        logic [99:0] got, exp;
        for (int c = 0; c < 400; c++) begin
            pc_en  = ($urandom_range(0, 9) < 8);
            stall  = ($urandom_range(0, 9) < 3);
            branch = ($urandom_range(0, 49) == 0);
            jal    = ($urandom_range(0, 59) == 0);
            jalr   = ($urandom_range(0, 69) == 0);
            branch_addr = $urandom;
            jump_addr   = $urandom;
            last_reg    = $urandom;
            rst = ($urandom_range(0, 149) == 0);
            if (lm_left == 0 && $urandom_range(0, 59) == 0) lm_left = $urandom_range(1, 5);
            load_mode = (lm_left != 0);
            load_we   = load_mode && $urandom_range(0, 1) == 1;
            load_addr = 8'($urandom);
            load_data = 8'($urandom);
            if (lm_left != 0) lm_left--;
            tick();
            if (mq.size() > 0)
                exp = {1'b1, 3'(mq.size()), mq[0][63:32], mq[0][63:32] + 32'd4, mq[0][31:0]};
            else
                exp = {1'b0, 3'd0, 32'h0, 32'h4, 32'h0};
            got = {o_valid, o_count, o_pc, o_next_pc, o_instr};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d got v=%0b cnt=%0d pc=%h npc=%h ins=%h want v=%0b cnt=%0d pc=%h npc=%h ins=%h",
                         c, got[99], got[98:96], got[95:64], got[63:32], got[31:0],
                         exp[99], exp[98:96], exp[95:64], exp[63:32], exp[31:0]);
            end
            if (m_popped) $display("txn pop pc=%h instr=%h", m_pop_e[63:32], m_pop_e[31:0]);
        end
        rst = 1'b0; load_mode = 1'b0; load_we = 1'b0;
        branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_en = 1'b0; stall = 1'b0;
        branch = 1'b0; jal = 1'b0; jalr = 1'b0;
        branch_addr = '0; jump_addr = '0; last_reg = '0;
        load_mode = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        m_fpc = '0; m_infl = 1'b0; m_infl_e = '0; m_popped = 1'b0; m_pop_e = '0;
        test_reset();
        load_image();
        test_basic();
        test_stall();
        test_redirect();
        test_jal_wrap();
        test_reset_midrun();
        test_load_mode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
